// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO behind the UART receiver: stores data plus error tag, registered read port, sticky overflow.
// Define UART_RX_FIFO_ERR_DROP_EN to discard errored bytes at the write port and tie rd_err low.
module uart_rx_fifo #(
  parameter int DEPTH       = 16,
  parameter int WIDTH       = 8,
  parameter int ALMOST_FULL = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_valid,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     wr_err,
  input  logic                     rd_en,
  input  logic                     clear_ovf,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_err,
  output logic                     rd_valid,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH:0]   mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_req;
  logic             wr_acc;
  logic             wr_drop;
  logic             rd_acc;
  logic [WIDTH:0]   wr_word;

`ifdef UART_RX_FIFO_ERR_DROP_EN
  // Errored bytes never reach the storage, so they cannot drop or overflow.
  assign wr_req  = wr_valid & ~wr_err;
  assign wr_word = {1'b0, wr_data};
`else
  assign wr_req  = wr_valid;
  assign wr_word = {wr_err, wr_data};
`endif

  assign empty       = (count == '0);
  assign full        = (count == CW'(DEPTH));
  assign almost_full = (count >= CW'(ALMOST_FULL));

  assign rd_acc  = rd_en & ~empty;
  assign wr_acc  = wr_req & (~full | rd_acc);
  assign wr_drop = wr_req & full & ~rd_acc;

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_word;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // When full, a same-cycle write lands on the slot being read; the read sees the old word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) rd_data <= mem[rd_ptr][WIDTH-1:0];
    end
  end

`ifdef UART_RX_FIFO_ERR_DROP_EN
  assign rd_err = 1'b0;
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      rd_err <= 1'b0;
    else if (rd_acc) rd_err <= mem[rd_ptr][WIDTH];
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         overflow <= 1'b0;
    else if (wr_drop)   overflow <= 1'b1;
    else if (clear_ovf) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo (DEPTH=16, WIDTH=8, ALMOST_FULL=12): vector table plus directed sequences.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_valid, wr_err, rd_en, clear_ovf;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       rd_err, rd_valid, empty, full, almost_full, overflow;
  logic [4:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH(16), .WIDTH(8), .ALMOST_FULL(12)) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_err(wr_err),
    .rd_en(rd_en), .clear_ovf(clear_ovf),
    .rd_data(rd_data), .rd_err(rd_err), .rd_valid(rd_valid),
    .empty(empty), .full(full), .almost_full(almost_full),
    .count(count), .overflow(overflow)
  );

  typedef struct {
    logic       wv;
    logic [7:0] wd;
    logic       we;
    logic       re;
    logic       co;
    logic       ev;
    logic [7:0] ed;
    logic       ee;
    int         ec;
    logic       eo;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wv, input logic [7:0] wd, input logic we,
                       input logic re, input logic co);
    wr_valid = wv; wr_data = wd; wr_err = we; rd_en = re; clear_ovf = co;
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b0;
    idle();
    #12;
    check("reset_count", count, 0);
    check("reset_empty", empty, 1);
    check("reset_full", full, 0);
    check("reset_afull", almost_full, 0);
    check("reset_rd_valid", rd_valid, 0);
    check("reset_rd_data", rd_data, 0);
    check("reset_rd_err", rd_err, 0);
    check("reset_ovf", overflow, 0);
    reset = 1'b1;
    #2;
    step();

    // wv wd we re co | ev ed ee count ovf
    vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1, 1'b0};
    vecs[1] = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2, 1'b0};
    vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 1, 1'b0};
    vecs[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b1, 0, 1'b0};
    vecs[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b1, 0, 1'b0};
    vecs[5] = '{1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b1, 1, 1'b0};
    vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h77, 1'b0, 0, 1'b0};
    vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h77, 1'b0, 0, 1'b0};

    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].wv, vecs[i].wd, vecs[i].we, vecs[i].re, vecs[i].co);
      step();
      check($sformatf("vec%0d_rd_valid", i), rd_valid, vecs[i].ev);
      check($sformatf("vec%0d_rd_data", i), rd_data, vecs[i].ed);
      check($sformatf("vec%0d_rd_err", i), rd_err, vecs[i].ee);
      check($sformatf("vec%0d_count", i), count, vecs[i].ec);
      check($sformatf("vec%0d_empty", i), empty, (vecs[i].ec == 0) ? 1 : 0);
      check($sformatf("vec%0d_ovf", i), overflow, vecs[i].eo);
    end
    idle();

    // Fill to full, watching the almost_full and full thresholds.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      step();
      check("fill_count", count, i + 1);
      check("fill_afull", almost_full, (i + 1 >= 12) ? 1 : 0);
      check("fill_full", full, (i + 1 == 16) ? 1 : 0);
    end
    drive(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    step();
    check("drop_count", count, 16);
    check("drop_ovf", overflow, 1);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step();
    check("clear_ovf", overflow, 0);
    drive(1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
    step();
    check("full_rw_count", count, 16);
    check("full_rw_ovf", overflow, 0);
    check("full_rw_valid", rd_valid, 1);
    check("full_rw_data", rd_data, 8'h00);
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      step();
      check("drain_valid", rd_valid, 1);
      check("drain_data", rd_data, (i < 15) ? i + 1 : 8'h55);
      check("drain_count", count, 15 - i);
    end
    idle();
    step();
    check("drained_valid", rd_valid, 0);
    check("drained_empty", empty, 1);

    // Drop coinciding with clear_ovf: the drop wins.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'(i + 8'h40), 1'b0, 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
    step();
    check("drop_vs_clear_ovf", overflow, 1);
    check("drop_vs_clear_count", count, 16);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step();
    check("clear_after_drop", overflow, 0);

    // Asynchronous reset with entries stored and a read in flight.
    reset = 1'b0;
    idle();
    #2;
    reset = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 8'(i + 8'h90), 1'b1, 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    step();
    idle();
    check("pre_reset_valid", rd_valid, 1);
    check("pre_reset_count", count, 5);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_count", count, 0);
    check("async_reset_empty", empty, 1);
    check("async_reset_valid", rd_valid, 0);
    check("async_reset_data", rd_data, 0);
    #3;
    reset = 1'b1;
    step();

`ifdef UART_RX_FIFO_ERR_DROP_EN
    drive(1'b1, 8'h12, 1'b1, 1'b0, 1'b0);
    step();
    check("err_drop_count", count, 0);
    check("err_drop_ovf", overflow, 0);
    idle();
`endif

    // Interleaved write/read pairs wrap both pointers more than twice.
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 8'(i + 8'h20), 1'b0, 1'b0, 1'b0);
      step();
      check("wrap_wr_count", count, 1);
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      step();
      check("wrap_rd_valid", rd_valid, 1);
      check("wrap_rd_data", rd_data, i + 8'h20);
      check("wrap_rd_count", count, 0);
    end
    idle();
    step();
    check("final_valid", rd_valid, 0);
    check("final_empty", empty, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer placed directly downstream of the UART receiver. It captures each completed byte, tagged with its parity/framing error flag, at the receiver's completion strobe. It holds up to DEPTH entries and hands them to the host logic through a registered read handshake. Occupancy, almost-full and sticky overflow status are exposed so software can pace reads and detect lost data.

## Interface
Parameters:
- DEPTH, 16: number of entries; power of two, minimum 2
- WIDTH, 8: data byte width
- ALMOST_FULL, 12: occupancy at or above which almost_full asserts; must satisfy 1 ≤ ALMOST_FULL ≤ DEPTH

Ports:
- clk  input  1  single clock; all logic on rising edge
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- wr_valid  input  1  one-cycle strobe from receiver: byte complete
- wr_data  input  WIDTH  received byte, sampled when wr_valid=1
- wr_err  input  1  parity/framing error for wr_data, sampled with wr_valid
- rd_en  input  1  read request from host
- clear_ovf  input  1  clears sticky overflow
- rd_data  output  WIDTH  registered read data
- rd_err  output  1  error tag of rd_data
- rd_valid  output  1  one-cycle pulse: rd_data/rd_err valid
- empty  output  1  occupancy == 0
- full  output  1  occupancy == DEPTH
- almost_full  output  1  occupancy ≥ ALMOST_FULL
- count  output  $clog2(DEPTH)+1  current occupancy
- overflow  output  1  sticky: a write was dropped because the FIFO was full

## Operation
- Storage: DEPTH × (WIDTH+1) array, holding data plus error tag. Write pointer and read pointer are $clog2(DEPTH) bits and wrap modulo DEPTH.
- The occupancy counter is maintained explicitly: +1 on accepted write only, −1 on accepted read only, unchanged when both or neither occur.
- Write accept: wr_valid=1 and (full=0 or read accepted same cycle). The entry is stored at wr_ptr and wr_ptr increments.
- Write drop: wr_valid=1, full=1 and no read this cycle. The entry is discarded, pointers are unchanged and overflow is set to 1.
- Read accept: rd_en=1 and empty=0. rd_data/rd_err are loaded from rd_ptr, rd_ptr increments and rd_valid=1 next cycle.
- rd_en with empty=1 is ignored: no pointer change and rd_valid=0. There is no write-to-read bypass, so a simultaneous write to an empty FIFO is stored and the read is ignored.
- rd_data/rd_err hold their last value when no read occurs.
- overflow clears on clear_ovf=1. If a drop and clear_ovf coincide in one cycle, the drop wins and overflow stays 1.
- empty, full, almost_full are combinational decodes of count.

## Timing
- Reset (reset=0, asynchronous):
  - Clears pointers, count, memory-valid state and outputs: rd_data=0, rd_err=0, rd_valid=0, count=0, empty=1, full=0, almost_full=0, overflow=0.
  - Memory contents need not be cleared.
  - A reset during a transfer discards all entries immediately.
- Deassertion is sampled synchronously by the first rising clk edge after reset=1.
- Write latency: an entry accepted at edge N is readable via rd_en in cycle N+1. count/empty update after edge N.
- Read latency: rd_en accepted at edge N gives rd_data valid and rd_valid=1 in the cycle following edge N, for exactly one cycle unless rd_en is held.
- Back-to-back reads with rd_en held produce one entry per cycle until empty. rd_valid drops the cycle after the last entry is read.
- Simultaneous read and write while full: both are accepted, count stays DEPTH and overflow is not set.

## Configuration
- UART_RX_FIFO_ERR_DROP_EN defined:
  - Writes with wr_err=1 are never stored. They do not touch pointers, count or overflow, even when full.
  - rd_err is tied to 0.
- Undefined: errored bytes are stored with their tag and returned on rd_err.

## Test plan
- Reset, write 0xA5 (err=0) then 0x3C (err=1), read twice -> rd_valid pulses; rd_data=0xA5/rd_err=0, then 0x3C/1; count 2→0, empty=1.
- Write 16 bytes 0x00..0x0F with DEPTH=16 -> almost_full at count=12, full at 16. A 17th write 0xFF -> dropped, overflow=1. Read all -> 0x00..0x0F in order.
- Full FIFO, same-cycle wr_valid(0x55)+rd_en -> count stays 16, overflow=0. The last entry read after draining is 0x55.
- rd_en while empty together with wr_valid(0x77) -> no rd_valid, count=1. Next rd_en -> rd_data=0x77.
- Pointer wrap: 40 interleaved write/read pairs of incrementing data -> every byte returned in order, count never exceeds 1.
- Reset asserted with 5 entries stored -> count=0, empty=1, rd_valid=0 immediately. With UART_RX_FIFO_ERR_DROP_EN, a write with err=1 -> count unchanged.
